// File: rtl/tis_pkg.sv
// tis_pkg: types and constants shared by the node port blocks.
//   NODE_DW      node word width
//   N_PORTS      writer ports per arbiter
//   PORT_IDX_W   width of a writer index
//   port_word_t  one node word, big-endian
//   fifo_entry_t buffered word tagged with the writer it came from
package tis_pkg;

    localparam int NODE_DW    = 8;
    localparam int N_PORTS    = 4;
    localparam int PORT_IDX_W = 2;

    typedef logic [0:NODE_DW-1] port_word_t;

    typedef struct packed {
        port_word_t                data;
        logic [0:PORT_IDX_W-1]     src;
    } fifo_entry_t;

endpackage

// File: rtl/port_fifo.sv
// port_fifo: synchronous FIFO, head visible combinationally from storage.
//   clk, rst_n  clock, asynchronous active-low reset (clears storage too)
//   push, wdata write wdata at the edge; ignored while full
//   pop         drop the head at the edge; ignored while empty
//   rdata       current head entry
//   full, empty occupancy status
module port_fifo
    import tis_pkg::*;
#(
    parameter int unsigned W     = NODE_DW + PORT_IDX_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [0:W-1] wdata,
    input  logic         pop,
    output logic [0:W-1] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [0:W-1]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/port_rr_arb.sv
// port_rr_arb: round-robin arbiter merging four node write ports into one.
//   clk, rst_n     clock, asynchronous active-low reset
//   in0..in3       writer data, valid while matching rrdy is high
//   rrdy0..rrdy3   writer has a word pending
//   rresp0..rresp3 one-cycle accept pulse back to the writer
//   out, src       head word and the index of the writer it came from
//   val            a word is available at the head
//   wresp          consumer takes the head word this cycle
//   full           buffer full (status only)
module port_rr_arb
    import tis_pkg::*;
#(
    parameter int unsigned DW    = NODE_DW,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:DW-1]         in0,
    input  logic [0:DW-1]         in1,
    input  logic [0:DW-1]         in2,
    input  logic [0:DW-1]         in3,
    input  logic                  rrdy0,
    input  logic                  rrdy1,
    input  logic                  rrdy2,
    input  logic                  rrdy3,
    output logic                  rresp0,
    output logic                  rresp1,
    output logic                  rresp2,
    output logic                  rresp3,
    output logic [0:DW-1]         out,
    output logic                  val,
    input  logic                  wresp,
    output logic [0:PORT_IDX_W-1] src,
    output logic                  full
);

    localparam int unsigned EW = DW + PORT_IDX_W;
    localparam logic [PORT_IDX_W-1:0] IDX_ONE = PORT_IDX_W'(1);

    logic [0:DW-1]           in_arr [N_PORTS];
    logic [N_PORTS-1:0]      rrdy_v;
    logic [N_PORTS-1:0]      rresp_q;
    logic [N_PORTS-1:0]      rresp_d;
    logic [N_PORTS-1:0]      eligible;
    logic [PORT_IDX_W-1:0]   ptr;
    logic [PORT_IDX_W-1:0]   grant;
    logic                    found;
    logic                    accept;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [0:EW-1]           push_data;
    logic [0:EW-1]           head;

    // First requester in round-robin order starting at 'start'; MSB = found.
    function automatic logic [PORT_IDX_W:0] rr_pick(
        input logic [N_PORTS-1:0]    req,
        input logic [PORT_IDX_W-1:0] start
    );
        logic [PORT_IDX_W:0]   res;
        logic [PORT_IDX_W-1:0] k;
        res = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            k = start + PORT_IDX_W'(i);
            if (!res[PORT_IDX_W] && req[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;
    assign rrdy_v    = {rrdy3, rrdy2, rrdy1, rrdy0};

    // A writer still holds rrdy in the cycle its rresp is visible; masking it
    // here keeps that stale request from being accepted a second time.
    assign eligible  = rrdy_v & ~rresp_q;

    always_comb begin
        {found, grant} = rr_pick(eligible, ptr);
        accept         = found && !fifo_full;
        rresp_d        = '0;
        if (accept) begin
            rresp_d[grant] = 1'b1;
        end
        push_data = {in_arr[grant], grant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            rresp_q <= '0;
        end else begin
            rresp_q <= rresp_d;
            if (accept) begin
                ptr <= grant + IDX_ONE;
            end
        end
    end

    port_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (push_data),
        .pop   (wresp),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rresp0 = rresp_q[0];
    assign rresp1 = rresp_q[1];
    assign rresp2 = rresp_q[2];
    assign rresp3 = rresp_q[3];
    assign out    = head[0:DW-1];
    assign src    = head[DW:EW-1];
    assign val    = !fifo_empty;
    assign full   = fifo_full;

endmodule

// File: doc/port_rr_arb.md
# port_rr_arb

Round-robin write-port arbiter that lets four node write ports share one downstream read port, e.g. four nodes feeding one stack/IO node. Toward the writers it behaves like a node read port (`in`/`rrdy`/`rresp`). Toward the consumer it behaves like a node write port (`out`/`val`/`wresp`). Accepted words are buffered in a small FIFO tagged with the source index, so writers are released before the consumer takes the data.

## Interface
Parameters:
- `DW`, 8, data width (node word).
- `DEPTH`, 2, FIFO entries; power of two, ≥2.

Ports (clock and reset first; all widths big-endian `[0:N-1]` as elsewhere in the node):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in0..in3`  in  DW each  writer data; valid while the matching `rrdy` is high.
- `rrdy0..rrdy3`  in  1 each  writer has a word pending; held with its data until `rresp` is seen.
- `rresp0..rresp3`  out  1 each  one-cycle accept pulse to the writer.
- `out`  out  DW  FIFO head data.
- `val`  out  1  FIFO non-empty.
- `wresp`  in  1  consumer accepted the head word this cycle.
- `src`  out  2  requester index of the head word.
- `full`  out  1  FIFO full (status only).

## Operation
- **Grant rule.** Eligible requester k: `rrdyk`=1 AND `rresp_k`=0 in the current cycle. The second term masks a writer that is dropping its request after an ack.
- **Accept.** If FIFO not full and at least one requester is eligible, pick the first eligible index in round-robin order starting at `ptr`.
- **On accept at edge:**
  - push {`in_k`, k} into the FIFO;
  - `rresp_k` ← 1 for exactly one cycle;
  - `ptr` ← (k+1) mod 4.
- At most one accept per cycle. All other `rresp` are 0.
- **Full.** No accept while full, even if a pop happens in the same cycle; the full check uses pre-edge occupancy.
- **Output side.**
  - `val` = occupancy≠0; `out`/`src` = head entry.
  - `wresp`=1 while `val`=1 pops the head at the edge.
  - `wresp` while `val`=0 is ignored.
- **Simultaneous push and pop** when not full: both take effect; occupancy unchanged.
- **Pointer.** Read/write pointers wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH)+1` bits.
- **No starvation.** A continuously requesting writer is granted within 4 accepts.
- **Reset (any time, async).**
  - `ptr`=0, FIFO empty.
  - `val`=0, `full`=0, all `rresp`=0, `out`=0, `src`=0.
  - Buffered words are discarded.
  - A writer mid-request sees no `rresp` and keeps `rrdy` high; it is re-arbitrated after reset release.
- No FSM beyond per-cycle arbitration. The state is `ptr`, the `rresp` register and the FIFO.

## Timing
- `rrdyk` high in cycle 0, FIFO empty, k wins: `rresp_k`=1 and `val`=1 with `out`=`in_k`, `src`=k in cycle 1.
- Writer must drop `rrdy` (or present a new word) by the edge ending the cycle after `rresp`. The mask prevents a double accept in the `rresp` cycle itself.
- Same writer re-requesting back-to-back is accepted at most every 2nd cycle. Different writers can be accepted every cycle.
- `wresp` in cycle c pops at the end of c; the next head appears in c+1.
- Throughput: 1 word/cycle with `DEPTH`≥2 and `wresp` held high.
- All outputs are registered or FIFO-storage driven; no combinational path from `rrdy`/`wresp` to any output.

## Structure
- Shared package `tis_pkg`:
  - `NODE_DW`=8;
  - `N_PORTS`=4;
  - `PORT_IDX_W`=2;
  - typedef `port_word_t` (`[0:NODE_DW-1]`);
  - typedef `fifo_entry_t` {data, src}.
- One sub-module: `port_fifo`. Parameterised synchronous FIFO with push/pop/full/empty/head, async active-low reset.
- The round-robin pick stays a combinational function inside `port_rr_arb`.

## Test plan
- **Single writer.** Reset, then `rrdy2`=1, `in2`=8'h5A → cycle 1: `rresp2`=1, `val`=1, `out`=5A, `src`=2. `wresp` in cycle 2 → `val`=0 in cycle 3.
- **Round-robin.** All four `rrdy` high with data 11/22/33/44, `wresp` held 1 → grant order 0,1,2,3,0… Each `rresp_k` is never high two consecutive cycles; `out` sequence is 11,22,33,44.
- **Full.** `wresp`=0, writers 0,1,3 requesting with DEPTH=2 → two accepts (0 then 1), then `full`=1 and no `rresp3`. `wresp` for one cycle → `rresp3` two cycles later, not in the pop cycle.
- **Simultaneous push/pop.** Occupancy 1, new accept and `wresp` in the same cycle → occupancy stays 1, head advances, `src` updates correctly.
- **Spurious/mid-op reset.**
  - `wresp`=1 with `val`=0 → no state change.
  - `rst_n` low mid-cycle with 2 entries buffered → immediately `val`=0, `rresp`=0, `ptr`=0.
  - After release, a still-asserted `rrdy1` is accepted.
